// File: rtl/avalon_tb_pkg.sv
// Shared types and helpers for the wait-state Avalon-MM bench memory.
// Used by the top FSM and the byte-lane memory array.
package avalon_tb_pkg;

   typedef enum logic {IDLE, STALL} ram_state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  be
   );
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/avalon_byte_mem.sv
// Word array with an async read port and one write port.
// The preload path wins over the byte-masked bus write.
module avalon_byte_mem
   import avalon_tb_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] rd_index,
   output logic [31:0]           rd_data,
   input  logic                  bus_we,
   input  logic [DEPTH_LOG2-1:0] bus_index,
   input  logic [31:0]           bus_data,
   input  logic [3:0]            bus_be,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_index,
   input  logic [31:0]           load_data
);

   logic [31:0] mem [2**DEPTH_LOG2];

   always_comb rd_data = mem[rd_index];

   always_ff @(posedge clk) begin
      if (load_en)
         mem[load_index] <= load_data;
      else if (bus_we)
         mem[bus_index] <= lane_merge(mem[bus_index], bus_data, bus_be);
   end

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM responder memory with programmable waitrequest stalls,
// a preload port, and a sticky master-protocol violation flag.
module avalon_wait_ram
   import avalon_tb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
   parameter int          DEPTH_LOG2  = 8,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic        waitrequest,
   output logic [31:0] readdata,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        proto_err
);

   localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(WAIT_CYCLES);

   ram_state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic req, complete, abort;
   logic stall_changed, err_now;
   logic [31:0] addr_q, wdata_q;
   logic [3:0] be_q;
   logic read_q, write_q;
   logic [DEPTH_LOG2-1:0] bus_index, load_index;
   logic [31:0] rd_data;

   assign req = read | write;

   // Offsets wrap silently: only the low index bits survive the cast.
   assign bus_index  = DEPTH_LOG2'((address - BASE_ADDR) >> 2);
   assign load_index = DEPTH_LOG2'((load_addr - BASE_ADDR) >> 2);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      complete   = 1'b0;
      abort      = 1'b0;
      if (!reset && !load_en) begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  if (WAIT_CYCLES == 0) begin
                     complete = 1'b1;
                  end else begin
                     state_next = STALL;
                     cnt_next   = CW'(1);
                  end
               end
            end
            STALL: begin
               if (!req) begin
                  abort      = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt == CNT_DONE) begin
                  complete   = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign waitrequest = req && !complete;
   assign readdata    = (complete && read) ? rd_data : 32'h0;

   assign stall_changed = (state == STALL) && req &&
                          ((address != addr_q) || (writedata != wdata_q) ||
                           (byteenable != be_q) || (read != read_q) ||
                           (write != write_q));

   assign err_now = abort || stall_changed || (read && write) ||
                    (req && (address[1:0] != 2'b00));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (err_now)
            proto_err <= 1'b1;
      end
   end

   // Last-cycle request snapshot for hold-stable checking during stalls.
   always_ff @(posedge clk) begin
      addr_q  <= address;
      wdata_q <= writedata;
      be_q    <= byteenable;
      read_q  <= read;
      write_q <= write;
   end

   avalon_byte_mem #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_mem (
      .clk       (clk),
      .rd_index  (bus_index),
      .rd_data   (rd_data),
      .bus_we    (complete && write && !read),
      .bus_index (bus_index),
      .bus_data  (writedata),
      .bus_be    (byteenable),
      .load_en   (load_en),
      .load_index(load_index),
      .load_data (load_data)
   );

endmodule
